// File: rtl/signal_sync_pkg.sv
// Shared helpers for the multi-channel level synchronizer: counter sizing,
// the minimum chain depth, and an elaboration-time parameter guard.
`ifndef SIGNAL_SYNC_PKG_SV
`define SIGNAL_SYNC_PKG_SV

// Expands to generate items that stop elaboration on an illegal chain depth or filter length.
`define SIGNAL_SYNC_CHECK_PARAMS(stages, filter) \
    if ((stages) < signal_sync_pkg::SYNC_MIN_STAGES) begin : gBadStages \
        $error("signal_sync: STAGES must be at least %0d", signal_sync_pkg::SYNC_MIN_STAGES); \
    end \
    if ((filter) < 0) begin : gBadFilter \
        $error("signal_sync: FILTER must not be negative"); \
    end

package signal_sync_pkg;

    localparam int SYNC_MIN_STAGES = 2;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic busy;
    } chanStatus_t;

    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // The stability counter needs a real bit even when filtering is disabled.
    function automatic int cntWidth(input int filter);
        return (clog2(filter + 1) < 1) ? 1 : clog2(filter + 1);
    endfunction

endpackage

`endif

// File: rtl/signal_sync_chan.sv
// One synchronized, glitch-filtered channel: flop chain, stability counter,
// output level register and coincident rise/fall pulse registers.
module signal_sync_chan
    import signal_sync_pkg::*;
#(
    parameter int   STAGES = 2,
    parameter int   FILTER = 0,
    parameter logic INIT   = 1'b0
) (
    input  logic        clkB,
    input  logic        rst_clkB,
    input  logic        inAsync,
    output chanStatus_t status
);

    localparam int               CNT_W   = cntWidth(FILTER);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER);

    `SIGNAL_SYNC_CHECK_PARAMS(STAGES, FILTER)

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] syncChain;

    logic             sLevel;
    logic             outLevel;
    logic             riseQ;
    logic             fallQ;
    logic [CNT_W-1:0] cnt;
    logic             countDone;

    assign sLevel    = syncChain[STAGES-1];
    assign countDone = (cnt == CNT_MAX);

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge clkB) begin
        if (rst_clkB) begin
            syncChain <= {STAGES{INIT}};
            outLevel  <= INIT;
            cnt       <= '0;
            riseQ     <= 1'b0;
            fallQ     <= 1'b0;
        end else begin
            syncChain <= {syncChain[STAGES-2:0], inAsync};
            // Pulses are registered alongside outLevel so they share its transition cycle.
            riseQ     <= ~outLevel &  sLevel & countDone;
            fallQ     <=  outLevel & ~sLevel & countDone;
            if (sLevel == outLevel) begin
                cnt <= '0;
            end else if (countDone) begin
                outLevel <= sLevel;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign status = '{level: outLevel, rise: riseQ, fall: fallQ, busy: (cnt != '0)};

endmodule

// File: rtl/signal_sync_filt.sv
// Multi-channel level synchronizer into the clkB domain; channels are independent,
// so this is not a coherent bus synchronizer.
module signal_sync_filt
    import signal_sync_pkg::*;
#(
    parameter int               WIDTH  = 1,
    parameter int               STAGES = 2,
    parameter int               FILTER = 0,
    parameter logic [WIDTH-1:0] INIT   = {WIDTH{1'b0}}
) (
    input  logic             clkB,
    input  logic             rst_clkB,
    input  logic [WIDTH-1:0] in_clkA,
    output logic [WIDTH-1:0] out_clkB,
    output logic [WIDTH-1:0] rise_clkB,
    output logic [WIDTH-1:0] fall_clkB,
    output logic [WIDTH-1:0] busy_clkB
);

    if (WIDTH < 1) begin : gBadWidth
        $error("signal_sync_filt: WIDTH must be at least 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : gChan
        chanStatus_t status;

        signal_sync_chan #(
            .STAGES (STAGES),
            .FILTER (FILTER),
            .INIT   (INIT[i])
        ) uChan (
            .clkB     (clkB),
            .rst_clkB (rst_clkB),
            .inAsync  (in_clkA[i]),
            .status   (status)
        );

        assign out_clkB[i]  = status.level;
        assign rise_clkB[i] = status.rise;
        assign fall_clkB[i] = status.fall;
        assign busy_clkB[i] = status.busy;
    end

endmodule

// File: tb/tb_signal_sync_filt.sv
// Six differently configured instances driven by directed and random stimulus,
// each compared every cycle against a window-based reference model.
module tb_signal_sync_filt;

    localparam int NDUT = 6;
    localparam int MAXS = 4;
    localparam int HIST = 8;

    logic clkB;
    initial clkB = 1'b0;
    always #5 clkB = ~clkB;

    // d0: defaults; d1: STAGES=3 FILTER=4; d2: WIDTH=4; d3: FILTER=4;
    // d4: INIT=1 FILTER=1; d5: WIDTH=8 STAGES=3 FILTER=2 (random)
    logic       rst0, rst1, rst2, rst3, rst4, rst5;
    logic [0:0] in0, in1, in3, in4;
    logic [3:0] in2;
    logic [7:0] in5;
    logic [0:0] out0, rise0, fall0, busy0;
    logic [0:0] out1, rise1, fall1, busy1;
    logic [3:0] out2, rise2, fall2, busy2;
    logic [0:0] out3, rise3, fall3, busy3;
    logic [0:0] out4, rise4, fall4, busy4;
    logic [7:0] out5, rise5, fall5, busy5;

    signal_sync_filt u0 (
        .clkB(clkB), .rst_clkB(rst0), .in_clkA(in0),
        .out_clkB(out0), .rise_clkB(rise0), .fall_clkB(fall0), .busy_clkB(busy0)
    );
    signal_sync_filt #(.WIDTH(1), .STAGES(3), .FILTER(4)) u1 (
        .clkB(clkB), .rst_clkB(rst1), .in_clkA(in1),
        .out_clkB(out1), .rise_clkB(rise1), .fall_clkB(fall1), .busy_clkB(busy1)
    );
    signal_sync_filt #(.WIDTH(4), .STAGES(2), .FILTER(0)) u2 (
        .clkB(clkB), .rst_clkB(rst2), .in_clkA(in2),
        .out_clkB(out2), .rise_clkB(rise2), .fall_clkB(fall2), .busy_clkB(busy2)
    );
    signal_sync_filt #(.WIDTH(1), .STAGES(2), .FILTER(4)) u3 (
        .clkB(clkB), .rst_clkB(rst3), .in_clkA(in3),
        .out_clkB(out3), .rise_clkB(rise3), .fall_clkB(fall3), .busy_clkB(busy3)
    );
    signal_sync_filt #(.WIDTH(1), .STAGES(2), .FILTER(1), .INIT(1'b1)) u4 (
        .clkB(clkB), .rst_clkB(rst4), .in_clkA(in4),
        .out_clkB(out4), .rise_clkB(rise4), .fall_clkB(fall4), .busy_clkB(busy4)
    );
    signal_sync_filt #(.WIDTH(8), .STAGES(3), .FILTER(2)) u5 (
        .clkB(clkB), .rst_clkB(rst5), .in_clkA(in5),
        .out_clkB(out5), .rise_clkB(rise5), .fall_clkB(fall5), .busy_clkB(busy5)
    );

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    function automatic int stagesOf(input int d);
        case (d)
            1, 5:    return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int filterOf(input int d);
        case (d)
            1, 3:    return 4;
            4:       return 1;
            5:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] initOf(input int d);
        return (d == 4) ? 8'h01 : 8'h00;
    endfunction

    function automatic logic [7:0] maskOf(input int d);
        case (d)
            2:       return 8'h0F;
            5:       return 8'hFF;
            default: return 8'h01;
        endcase
    endfunction

    // Reference: s is the input delayed STAGES edges; a bit flips once the last
    // FILTER+1 observed s values since reset all disagree with the current output.
    logic [7:0] mChain [NDUT][MAXS];
    logic [7:0] mHist  [NDUT][HIST];
    int         mHistN [NDUT];
    logic [7:0] mOut   [NDUT];
    logic [7:0] mRise  [NDUT];
    logic [7:0] mFall  [NDUT];
    logic [7:0] mBusy  [NDUT];

    task automatic modelStep(input int d, input logic [7:0] inV, input logic rstV);
        int         st;
        int         fl;
        int         run;
        bit         allDiff;
        logic [7:0] sNow;
        logic [7:0] newOut;
        st = stagesOf(d);
        fl = filterOf(d);
        if (rstV) begin
            for (int i = 0; i < MAXS; i++) mChain[d][i] = initOf(d);
            mHistN[d] = 0;
            mOut[d]   = initOf(d);
            mRise[d]  = 8'h00;
            mFall[d]  = 8'h00;
            mBusy[d]  = 8'h00;
        end else begin
            sNow = mChain[d][st-1];
            for (int i = HIST - 1; i > 0; i--) mHist[d][i] = mHist[d][i-1];
            mHist[d][0] = sNow;
            if (mHistN[d] < HIST) mHistN[d] = mHistN[d] + 1;
            newOut = mOut[d];
            for (int b = 0; b < 8; b++) begin
                allDiff = (mHistN[d] >= fl + 1);
                for (int j = 0; j <= fl; j++) begin
                    if (j < mHistN[d] && mHist[d][j][b] == mOut[d][b]) allDiff = 1'b0;
                end
                if (allDiff) newOut[b] = ~mOut[d][b];
            end
            mRise[d] = newOut & ~mOut[d];
            mFall[d] = mOut[d] & ~newOut;
            mOut[d]  = newOut;
            for (int b = 0; b < 8; b++) begin
                run = 0;
                while (run < mHistN[d] && mHist[d][run][b] != mOut[d][b]) run = run + 1;
                mBusy[d][b] = (run > 0);
            end
            for (int i = MAXS - 1; i > 0; i--) mChain[d][i] = mChain[d][i-1];
            mChain[d][0] = inV & maskOf(d);
        end
    endtask

    always @(posedge clkB) begin
        modelStep(0, 8'(in0), rst0);
        modelStep(1, 8'(in1), rst1);
        modelStep(2, 8'(in2), rst2);
        modelStep(3, 8'(in3), rst3);
        modelStep(4, 8'(in4), rst4);
        modelStep(5, in5, rst5);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checkCount = checkCount + 1;
        assert (obs === exp) passCount = passCount + 1;
        else begin
            failCount = failCount + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        check("d0.out",  8'(out0),  mOut[0]);  check("d0.rise", 8'(rise0), mRise[0]);
        check("d0.fall", 8'(fall0), mFall[0]); check("d0.busy", 8'(busy0), mBusy[0]);
        check("d1.out",  8'(out1),  mOut[1]);  check("d1.rise", 8'(rise1), mRise[1]);
        check("d1.fall", 8'(fall1), mFall[1]); check("d1.busy", 8'(busy1), mBusy[1]);
        check("d2.out",  8'(out2),  mOut[2]);  check("d2.rise", 8'(rise2), mRise[2]);
        check("d2.fall", 8'(fall2), mFall[2]); check("d2.busy", 8'(busy2), mBusy[2]);
        check("d3.out",  8'(out3),  mOut[3]);  check("d3.rise", 8'(rise3), mRise[3]);
        check("d3.fall", 8'(fall3), mFall[3]); check("d3.busy", 8'(busy3), mBusy[3]);
        check("d4.out",  8'(out4),  mOut[4]);  check("d4.rise", 8'(rise4), mRise[4]);
        check("d4.fall", 8'(fall4), mFall[4]); check("d4.busy", 8'(busy4), mBusy[4]);
        check("d5.out",  out5,      mOut[5]);  check("d5.rise", rise5,     mRise[5]);
        check("d5.fall", fall5,     mFall[5]); check("d5.busy", busy5,     mBusy[5]);
    endtask

    task automatic tick();
        @(posedge clkB);
        @(negedge clkB);
        checkAll();
    endtask

    initial begin
        logic [7:0] flip;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0; in4 = '0; in5 = '0;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1; rst4 = 1'b1; rst5 = 1'b1;

        tick();
        tick();
        check("reset.d0.out",   8'(out0), 8'h00);
        check("reset.d2.out",   8'(out2), 8'h00);
        check("reset.d4.out",   8'(out4), 8'h01);
        check("reset.d4.fall",  8'(fall4), 8'h00);
        check("reset.d1.busy",  8'(busy1), 8'h00);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0; rst4 = 1'b0; rst5 = 1'b0;

        // INIT=1 channel with input held low through reset: one fall at edge 1+STAGES+FILTER.
        for (int e = 1; e <= 6; e++) begin
            tick();
            check("init1.out",  8'(out4),  (e < 4) ? 8'h01 : 8'h00);
            check("init1.fall", 8'(fall4), 8'(e == 4));
            check("init1.rise", 8'(rise4), 8'h00);
            check("init1.busy", 8'(busy4), 8'(e == 3));
        end

        // Default configuration: output follows two edges after the first sampling edge.
        in0 = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("dflt.out",  8'(out0),  8'(e >= 3));
            check("dflt.rise", 8'(rise0), 8'(e == 3));
            check("dflt.fall", 8'(fall0), 8'h00);
        end

        // Four independent channels, then a pattern swap producing rise and fall together.
        in2 = 4'b1010;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("wide.out",  8'(out2),  (e >= 3) ? 8'h0A : 8'h00);
            check("wide.rise", 8'(rise2), (e == 3) ? 8'h0A : 8'h00);
            check("wide.fall", 8'(fall2), 8'h00);
        end
        in2 = 4'b0101;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("swap.out",  8'(out2),  (e >= 3) ? 8'h05 : 8'h0A);
            check("swap.rise", 8'(rise2), (e == 3) ? 8'h05 : 8'h00);
            check("swap.fall", 8'(fall2), (e == 3) ? 8'h0A : 8'h00);
        end

        // STAGES=3 FILTER=4: a 3-cycle pulse is rejected, a 10-cycle pulse passes.
        in1 = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("glitch.out",  8'(out1),  8'h00);
            check("glitch.rise", 8'(rise1), 8'h00);
            check("glitch.busy", 8'(busy1), 8'(e >= 4 && e <= 6));
            if (e == 3) in1 = 1'b0;
        end
        in1 = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check("pulse.out",  8'(out1),  8'(e >= 8 && e <= 17));
            check("pulse.rise", 8'(rise1), 8'(e == 8));
            check("pulse.fall", 8'(fall1), 8'(e == 18));
            check("pulse.busy", 8'(busy1), 8'((e >= 4 && e <= 7) || (e >= 14 && e <= 17)));
            if (e == 10) in1 = 1'b0;
        end

        // FILTER=4: reset lands while a change is pending with the counter at 2.
        in3 = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check("pend.out",  8'(out3),  8'h00);
            check("pend.busy", 8'(busy3), 8'(e >= 3));
        end
        rst3 = 1'b1;
        tick();
        check("midrst.out",  8'(out3),  8'h00);
        check("midrst.busy", 8'(busy3), 8'h00);
        check("midrst.rise", 8'(rise3), 8'h00);
        check("midrst.fall", 8'(fall3), 8'h00);
        rst3 = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("rerun.out",  8'(out3),  8'(e >= 7));
            check("rerun.rise", 8'(rise3), 8'(e == 7));
            check("rerun.busy", 8'(busy3), 8'(e >= 3 && e <= 6));
        end

        // Random toggling on eight channels with occasional resets; checkAll does the comparing.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            flip = 8'($urandom) & 8'($urandom);
            if ((cyc % 64) >= 32) flip = flip & 8'($urandom);
            in5  = in5 ^ flip;
            rst5 = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst5 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
